multi_digit_timer: RTL

MULTI_DIGIT_TIMER -- requirements
Module: multi_digit_timer

---
 rtl/multi_digit_timer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_digit_timer.sv
// multi_digit_timer
//   BCD up/down timer with NUM_DIGITS digits, run/pause and lap (display
//   freeze) controls, and a time-multiplexed 7-segment display driver.
//
// Ports
//   clock     : sole clock, rising edge
//   reset     : synchronous active-high; loads the counter for the sampled mode
//   toggle    : level input, rising edge toggles run/pause
//   lap       : level input, rising edge toggles display freeze
//   mode_sel  : 00 up from 0, 01 up from preset, 10 down from all-9s,
//               11 down from preset (sampled only while reset is high)
//   preset    : BCD load value, digit i at [4i+3:4i]
//   seg       : active-low segments {g,f,e,d,c,b,a}
//   dp        : active-low decimal point
//   an        : active-low digit enables, an[i] = digit i
//   running   : high while counting
//   done      : high once the terminal count has been reached
module multi_digit_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    toggle,
  input  logic                    lap,
  input  logic [1:0]              mode_sel,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    running,
  output logic                    done
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0] TICK_LAST    = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] DP_IDX       = IW'(DP_POS);
  localparam logic [W-1:0]  ALL_NINES    = {NUM_DIGITS{4'd9}};
  localparam logic [W-1:0]  ALL_ZEROS    = {W{1'b0}};

  // Force every preset digit into the 0..9 range.
  function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Counter value loaded by reset for a given mode.
  function automatic logic [W-1:0] f_load(input logic [1:0] m, input logic [W-1:0] p);
    logic [W-1:0] r;
    case (m)
      2'b00:   r = ALL_ZEROS;
      2'b01:   r = f_clamp(p);
      2'b10:   r = ALL_NINES;
      2'b11:   r = f_clamp(p);
      default: r = ALL_ZEROS;
    endcase
    return r;
  endfunction

  // BCD +1 with ripple carry.
  function automatic logic [W-1:0] f_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD -1 with ripple borrow.
  function automatic logic [W-1:0] f_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; blank otherwise.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic          r_down;
  logic [W-1:0]  r_count;
  logic [W-1:0]  r_disp;
  logic          r_running;
  logic          r_done;
  logic          r_lap_hold;
  logic          r_toggle_q;
  logic          r_lap_q;
  logic          r_rst_q;
  logic [PW-1:0] r_presc;
  logic [RW-1:0] r_refresh;
  logic [IW-1:0] r_idx;

  logic          w_tick;
  logic          w_tog_edge;
  logic          w_lap_edge;
  logic [W-1:0]  w_count_step;
  logic          w_step_terminal;
  logic          w_cur_terminal;
  logic [W-1:0]  w_disp_val;
  logic [3:0]    w_digit;

  // Tick, edge detection and next-count evaluation.
  always_comb begin
    w_tick       = r_running && (r_presc == TICK_LAST);
    w_tog_edge   = toggle & ~r_toggle_q;
    w_lap_edge   = lap & ~r_lap_q;
    if (r_down) begin
      w_count_step    = f_dec(r_count);
      w_step_terminal = (w_count_step == ALL_ZEROS);
      w_cur_terminal  = (r_count == ALL_ZEROS);
    end else begin
      w_count_step    = f_inc(r_count);
      w_step_terminal = (w_count_step == ALL_NINES);
      w_cur_terminal  = (r_count == ALL_NINES);
    end
  end

  // Counter, run/done control, prescaler and lap capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_down     <= mode_sel[1];
      r_count    <= f_load(mode_sel, preset);
      r_disp     <= ALL_ZEROS;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_lap_hold <= 1'b0;
      r_presc    <= {PW{1'b0}};
      r_toggle_q <= toggle;
      r_lap_q    <= lap;
      r_rst_q    <= 1'b1;
    end else begin
      r_toggle_q <= toggle;
      r_lap_q    <= lap;
      r_rst_q    <= 1'b0;

      // Capture uses the pre-tick count, so a same-cycle tick is not seen.
      if (w_lap_edge) begin
        r_lap_hold <= ~r_lap_hold;
        if (!r_lap_hold) r_disp <= r_count;
      end

      if (w_tick) r_count <= w_count_step;

      if (r_running) begin
        r_presc <= w_tick ? {PW{1'b0}} : r_presc + PW'(1);
      end

      // A load that is already terminal reports done on the first cycle
      // out of reset; a terminal tick wins over a same-cycle toggle.
      if (r_rst_q && w_cur_terminal) begin
        r_done    <= 1'b1;
        r_running <= 1'b0;
      end else if (w_tick && w_step_terminal) begin
        r_done    <= 1'b1;
        r_running <= 1'b0;
      end else if (w_tog_edge) begin
        r_running <= r_done ? 1'b0 : ~r_running;
      end
    end
  end

  // Free-running display refresh and digit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_refresh <= {RW{1'b0}};
      r_idx     <= {IW{1'b0}};
    end else if (r_refresh == REFRESH_LAST) begin
      r_refresh <= {RW{1'b0}};
      r_idx     <= (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  // Display decode from registers only.
  always_comb begin
    w_disp_val = r_lap_hold ? r_disp : r_count;
    w_digit    = 4'd0;
    an         = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit = w_disp_val[4*i +: 4];
        an[i]   = 1'b0;
      end
    end
    seg = f_seg(w_digit);
    dp  = (r_idx == DP_IDX) ? 1'b0 : 1'b1;
  end

  assign running = r_running;
  assign done    = r_done;

endmodule
